mod_div_seq: RTL and testbench

Sequential signed 8-bit divider: the inverse of the combinational multiplier `mod_mult` in the determinant datapath of the arithmetic coprocessor. It takes two two's-complement operands under a start/done handshake and produces quotient and remainder. It also flags overflow and divide-by-zero, using the same `resultado`/`flag_overflow` conventions as the multiplier. It sits beside `mod_mult` and is driven by the coprocessor control FSM.

---
 rtl/mod_arith_pkg.sv | 16 +
 rtl/mod_abs_neg.sv | 16 +
 rtl/mod_div_seq.sv | 156 +++++++++++++++
 tb/tb_mod_div_seq.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/mod_arith_pkg.sv
// Shared constants and state encoding for the coprocessor arithmetic blocks.
package mod_arith_pkg;

  localparam int WIDTH = 8;
  localparam int ITER  = WIDTH;
  localparam int CNT_W = $clog2(ITER);
  localparam logic [WIDTH-1:0] MIN_NEG = 8'h80;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/mod_abs_neg.sv
// Conditional two's-complement negate. Tie neg to x[W-1] to get |x|
// (|MIN_NEG| comes out as MIN_NEG, i.e. 128 when read as unsigned).
module mod_abs_neg #(
  parameter int W = 8
) (
  input  logic [W-1:0] x,
  input  logic         neg,
  output logic [W-1:0] y
);

  // Negate when requested, pass through otherwise
  always_comb begin
    y = neg ? (~x + W'(1)) : x;
  end

endmodule

// File: rtl/mod_div_seq.sv
// Sequential signed restoring divider: quotient truncates toward zero,
// remainder takes the dividend's sign. One quotient bit per CALC cycle.
module mod_div_seq
  import mod_arith_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] resultado,
  output logic [WIDTH-1:0] resto,
  output logic             flag_overflow,
  output logic             flag_div_zero
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(ITER - 1);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sa_q, sa_d, sb_q, sb_d;
  logic [WIDTH-1:0] bmag_q, bmag_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;   // dividend magnitude, shifted out MSB first
  logic [WIDTH-1:0] rem_q, rem_d;   // partial remainder; always < |b| so 8 bits hold it
  logic [WIDTH-1:0] quo_q, quo_d;   // quotient magnitude shift register
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] resto_q, resto_d;
  logic             ovf_q, ovf_d, dz_q, dz_d, done_q, done_d;

  logic [WIDTH-1:0] amag, bmag, q_sgn, r_sgn;
  logic [WIDTH:0]   shl, diff;

  // Operand magnitudes for latching in IDLE
  mod_abs_neg #(.W(WIDTH)) u_abs_a (.x(a), .neg(a[WIDTH-1]), .y(amag));
  mod_abs_neg #(.W(WIDTH)) u_abs_b (.x(b), .neg(b[WIDTH-1]), .y(bmag));
  // Sign restoration used in FIX
  mod_abs_neg #(.W(WIDTH)) u_neg_q (.x(quo_q), .neg(sa_q ^ sb_q), .y(q_sgn));
  mod_abs_neg #(.W(WIDTH)) u_neg_r (.x(rem_q), .neg(sa_q),        .y(r_sgn));

  // 9-bit working remainder and trial subtraction for one restoring step
  always_comb begin
    shl  = {rem_q, dvd_q[WIDTH-1]};
    diff = shl - {1'b0, bmag_q};
  end

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    bmag_d  = bmag_q;
    dvd_d   = dvd_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    res_d   = res_q;
    resto_d = resto_q;
    ovf_d   = ovf_q;
    dz_d    = dz_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          sa_d   = a[WIDTH-1];
          sb_d   = b[WIDTH-1];
          bmag_d = bmag;
          dvd_d  = amag;
          rem_d  = '0;
          quo_d  = '0;
          cnt_d  = '0;
          if (b == '0) begin
            res_d   = '0;
            resto_d = a;
            dz_d    = 1'b1;
            ovf_d   = 1'b0;
            state_d = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        // Negative trial result shows up as bit WIDTH set: restore
        if (!diff[WIDTH]) begin
          rem_d = diff[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shl[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) state_d = FIX;
      end
      FIX: begin
        // Only a positive 128 quotient (-128 / -1) is unrepresentable
        res_d   = q_sgn;
        resto_d = r_sgn;
        ovf_d   = ~(sa_q ^ sb_q) & quo_q[WIDTH-1];
        dz_d    = 1'b0;
        state_d = DONE;
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      bmag_q  <= '0;
      dvd_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      res_q   <= '0;
      resto_q <= '0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      bmag_q  <= bmag_d;
      dvd_q   <= dvd_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      res_q   <= res_d;
      resto_q <= resto_d;
      ovf_q   <= ovf_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
    end
  end

  // done is registered out of DONE, so busy drops the same cycle done rises
  always_comb begin
    busy          = (state_q != IDLE);
    done          = done_q;
    resultado     = res_q;
    resto         = resto_q;
    flag_overflow = ovf_q;
    flag_div_zero = dz_q;
  end

endmodule

// File: tb/tb_mod_div_seq.sv
// Bench for mod_div_seq: directed table, handshake corner sequences, and
// randomized operands checked against plain signed integer division.
module tb_mod_div_seq;

  logic       clk = 1'b0;
  logic       rst_n, start, busy, done, flag_overflow, flag_div_zero;
  logic [7:0] a, b, resultado, resto;

  int checks = 0;
  int failures = 0;

  mod_div_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .resultado(resultado), .resto(resto),
    .flag_overflow(flag_overflow), .flag_div_zero(flag_div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a, b, q, r;
    bit         ovf, dz;
    int         lat;
  } vec_t;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  // Reference: signed integer division truncates toward zero, % follows dividend
  task automatic model(input logic [7:0] ma, input logic [7:0] mb,
                       output logic [7:0] q, output logic [7:0] r,
                       output bit ovf, output bit dz, output int lat);
    int ai, bi, qi, ri;
    ai = int'($signed(ma));
    bi = int'($signed(mb));
    if (bi == 0) begin
      q = 8'h00; r = ma; ovf = 1'b0; dz = 1'b1; lat = 1;
    end else begin
      qi = ai / bi;
      ri = ai % bi;
      q = qi[7:0]; r = ri[7:0]; ovf = (qi > 127); dz = 1'b0; lat = 10;
    end
  endtask

  // Issue one op from a post-edge point; return cycles from the start edge to done
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_in, output int lat);
    a = ta; b = tb_in; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom);
    chk("busy_after_start", int'(busy), 1);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done) begin lat = k; break; end
    end
    chk("busy_at_done", int'(busy), 0);
  endtask

  task automatic check_res(input string tag, input vec_t v, input int lat);
    chk({tag, "_resultado"}, int'(resultado), int'(v.q));
    chk({tag, "_resto"}, int'(resto), int'(v.r));
    chk({tag, "_ovf"}, int'(flag_overflow), int'(v.ovf));
    chk({tag, "_dz"}, int'(flag_div_zero), int'(v.dz));
    chk({tag, "_latency"}, lat, v.lat);
  endtask

  vec_t tbl[10];
  vec_t v;
  int   lat, ndone;

  initial begin
    tbl[0] = '{8'd100, 8'd7,   8'd14,  8'd2,   1'b0, 1'b0, 10};
    tbl[1] = '{8'h9C,  8'd7,   8'hF2,  8'hFE,  1'b0, 1'b0, 10};
    tbl[2] = '{8'd100, 8'hF9,  8'hF2,  8'h02,  1'b0, 1'b0, 10};
    tbl[3] = '{8'h80,  8'hFF,  8'h80,  8'h00,  1'b1, 1'b0, 10};
    tbl[4] = '{8'h80,  8'h01,  8'h80,  8'h00,  1'b0, 1'b0, 10};
    tbl[5] = '{8'd5,   8'd0,   8'h00,  8'h05,  1'b0, 1'b1, 1};
    tbl[6] = '{8'd0,   8'd9,   8'h00,  8'h00,  1'b0, 1'b0, 10};
    tbl[7] = '{8'h7F,  8'h80,  8'h00,  8'h7F,  1'b0, 1'b0, 10};
    tbl[8] = '{8'h80,  8'h80,  8'h01,  8'h00,  1'b0, 1'b0, 10};
    tbl[9] = '{8'h81,  8'd2,   8'hC1,  8'hFF,  1'b0, 1'b0, 10};

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_resultado", int'(resultado), 0);
    chk("rst_resto", int'(resto), 0);
    chk("rst_flags", int'({flag_overflow, flag_div_zero}), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table, issued back-to-back right after each done
    for (int i = 0; i < 10; i++) begin
      run_op(tbl[i].a, tbl[i].b, lat);
      check_res($sformatf("tbl%0d", i), tbl[i], lat);
    end

    // Start pulsed mid-CALC is ignored: only 50/3 completes, once
    a = 8'd50; b = 8'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0; lat = -1;
    for (int k = 1; k <= 25; k++) begin
      if (k == 3) begin a = 8'd9; b = 8'd2; start = 1'b1; end
      if (k == 4) start = 1'b0;
      @(posedge clk); #1;
      if (done) begin ndone++; if (lat < 0) lat = k; end
      if (k == lat) begin
        chk("ign_calc_resultado", int'(resultado), 16);
        chk("ign_calc_resto", int'(resto), 2);
      end
    end
    chk("ign_calc_done_count", ndone, 1);
    chk("ign_calc_latency", lat, 10);

    // Start during DONE cycle is ignored
    a = 8'd20; b = 8'd6; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0;
    for (int k = 1; k <= 25; k++) begin
      if (k == 9) begin a = 8'd7; b = 8'd7; start = 1'b1; end
      if (k == 10) start = 1'b0;
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("ign_done_count", ndone, 1);
    chk("ign_done_resultado", int'(resultado), 3);
    chk("ign_done_resto", int'(resto), 2);

    // Reset mid-operation: outputs clear at once, no done afterwards
    a = 8'd77; b = 8'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_resultado", int'(resultado), 0);
    chk("midrst_resto", int'(resto), 0);
    chk("midrst_flags", int'({flag_overflow, flag_div_zero}), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("midrst_no_done", ndone, 0);

    // Randomized operands against the integer model
    for (int i = 0; i < 150; i++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom);
      rb = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom);
      if (i == 0) begin ra = 8'h80; rb = 8'hFF; end
      model(ra, rb, v.q, v.r, v.ovf, v.dz, v.lat);
      run_op(ra, rb, lat);
      check_res($sformatf("rnd%0d_%0h_%0h", i, ra, rb), v, lat);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
